// File: rtl/tff_bank_arbiter.sv
// Round-robin arbiter sharing a bank of toggle/set/clear flip-flops among four requesters.
// Optional contention counter built only when TFF_ARB_STATS_EN is defined.
module tff_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req,
  input  logic [7:0]          op,
  input  logic [4*IDXW-1:0]   idx,
  output logic [3:0]          gnt,
  output logic                err,
  output logic [WIDTH-1:0]    q,
  output logic [7:0]          conflict_cnt
);

  localparam logic [IDXW:0] IdxLimit = (IDXW+1)'(WIDTH);

  logic [1:0]       ptr;
  logic [3:0]       elig;
  logic             found;
  logic [1:0]       win;
  logic [1:0]       wOp;
  logic [IDXW-1:0]  wIdx;
  logic [WIDTH-1:0] bitMask;

  assign elig = req & ~gnt;

  // Search eligible requesters starting at ptr; the last granted one is masked out.
  always_comb begin
    logic [1:0] cand;
    found = 1'b0;
    win   = 2'd0;
    cand  = 2'd0;
    for (int j = 0; j < 4; j++) begin
      cand = ptr + 2'(j);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign wOp     = op[2*win +: 2];
  assign wIdx    = idx[win*IDXW +: IDXW];
  assign bitMask = WIDTH'(1) << wIdx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt <= '0;
      err <= 1'b0;
      q   <= '0;
      ptr <= '0;
    end else begin
      gnt <= '0;
      err <= 1'b0;
      if (found) begin
        gnt <= 4'b0001 << win;
        ptr <= win + 2'd1;
        if ({1'b0, wIdx} >= IdxLimit) begin
          err <= 1'b1;
        end else begin
          case (wOp)
            2'b01:   q <= q ^ bitMask;
            2'b10:   q <= q | bitMask;
            2'b11:   q <= q & ~bitMask;
            default: q <= q;
          endcase
        end
      end
    end
  end

`ifdef TFF_ARB_STATS_EN
  logic multiElig;

  assign multiElig = (elig & (elig - 4'd1)) != 4'd0;

  // Saturating count of cycles where two or more requesters competed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (multiElig && conflict_cnt != 8'hFF) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_tff_bank_arbiter.sv
// Randomized bench for tff_bank_arbiter against a cycle-level behavioural model.
// Uses WIDTH=6 so out-of-range indices are reachable.
module tb_tff_bank_arbiter;

  localparam int WIDTH = 6;
  localparam int IDXW  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req;
  logic [7:0]       op;
  logic [4*IDXW-1:0] idx;
  logic [3:0]       gnt;
  logic             err;
  logic [WIDTH-1:0] q;
  logic [7:0]       conflict_cnt;

  int total = 0;
  int bad   = 0;

  int         mPtr;
  int         mLast;
  int         mCnt;
  logic [WIDTH-1:0] mQ;
  logic [3:0] expGnt;
  logic       expErr;

  tff_bank_arbiter #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx),
    .gnt(gnt), .err(err), .q(q), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPtr = 0; mLast = -1; mCnt = 0; mQ = '0; expGnt = '0; expErr = 1'b0;
  endtask

  // Next-cycle expectation from the current inputs and the model's history.
  task automatic modelStep();
    int win, nElig, bitNo, opc;
    win = -1;
    nElig = 0;
    for (int k = 0; k < 4; k++)
      if (req[k] && k != mLast) nElig++;
    for (int j = 0; j < 4; j++) begin
      int k = (mPtr + j) % 4;
      if (win < 0 && req[k] && k != mLast) win = k;
    end
    expGnt = '0;
    expErr = 1'b0;
    if (win >= 0) begin
      expGnt[win] = 1'b1;
      mPtr  = (win + 1) % 4;
      opc   = (op >> (2*win)) & 3;
      bitNo = (idx >> (IDXW*win)) & ((1 << IDXW) - 1);
      if (bitNo >= WIDTH) expErr = 1'b1;
      else if (opc == 1) mQ[bitNo] = ~mQ[bitNo];
      else if (opc == 2) mQ[bitNo] = 1'b1;
      else if (opc == 3) mQ[bitNo] = 1'b0;
    end
    mLast = win;
`ifdef TFF_ARB_STATS_EN
    if (nElig >= 2 && mCnt < 255) mCnt++;
`endif
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [7:0] o, input logic [4*IDXW-1:0] ix);
    req = r; op = o; idx = ix;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("gnt", 32'(gnt), 32'(expGnt));
    checkOutput("err", 32'(err), 32'(expErr));
    checkOutput("q", 32'(q), 32'(mQ));
    checkOutput("conflict_cnt", 32'(conflict_cnt), 32'(mCnt));
  endtask

  initial begin
    rst = 1'b1; req = '0; op = '0; idx = '0;
    modelReset();
    @(posedge clk);
    #1;
    checkOutput("reset gnt", 32'(gnt), 32'd0);
    checkOutput("reset q", 32'(q), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    checkOutput("reset cnt", 32'(conflict_cnt), 32'd0);
    rst = 1'b0;

    // Directed: requester 1 set/toggle/clear, then same-bit collision, then out-of-range.
    applyStimulus(4'b0010, 8'b0000_1000, 12'(3 << 3));
    checkOutput("set idx3", 32'(q), 32'h08);
    applyStimulus(4'b0000, 8'h00, '0);
    applyStimulus(4'b0010, 8'b0000_0100, 12'(3 << 3));
    checkOutput("toggle idx3", 32'(q), 32'h00);
    applyStimulus(4'b0000, 8'h00, '0);
    applyStimulus(4'b0101, 8'b0001_0001, 12'((5 << 6) | 5));
    applyStimulus(4'b0100, 8'b0001_0001, 12'((5 << 6) | 5));
    applyStimulus(4'b0000, 8'h00, '0);
    applyStimulus(4'b1000, 8'b1000_0000, 12'(7 << 9));
    checkOutput("oor err", 32'(err), 32'd1);
    applyStimulus(4'b0000, 8'h00, '0);

    for (int n = 0; n < 400; n++)
      applyStimulus(4'($urandom), 8'($urandom), 12'($urandom));

    // Reset asserted between edges with a command pending.
    applyStimulus(4'b0001, 8'b0000_0001, 12'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset gnt", 32'(gnt), 32'd0);
    checkOutput("midreset q", 32'(q), 32'd0);
    checkOutput("midreset cnt", 32'(conflict_cnt), 32'd0);
    modelReset();
    #1 rst = 1'b0;
    applyStimulus(4'b0001, 8'b0000_0001, 12'd0);
    checkOutput("post reset gnt", 32'(gnt), 32'b0001);

    // Full load drives the counter into saturation.
    for (int n = 0; n < 300; n++)
      applyStimulus(4'b1111, 8'($urandom), 12'($urandom));
`ifdef TFF_ARB_STATS_EN
    checkOutput("saturated cnt", 32'(conflict_cnt), 32'd255);
`else
    checkOutput("disabled cnt", 32'(conflict_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tff_bank_arbiter.md
# tff_bank_arbiter

Round-robin controller that shares a bank of toggle flip-flops (`WIDTH` bits of T/set/clear state) between four requesters. Each cycle it selects at most one pending command, applies it to the addressed bit, and returns a one-cycle grant. It sits between independent control agents and the shared flag register that they all read through `q`.

## Interface

Parameters:
- `WIDTH`, default 8: number of flip-flops in the bank, 2..32.
- `IDXW`, default 3: width of each bit-index field, must satisfy 2^IDXW >= WIDTH.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, 4: per-requester command-pending flag. Requester k owns bit k.
- `op`, input, 8: 2-bit opcode per requester, in `op[2k+1:2k]`. 00 = nop, 01 = toggle, 10 = set, 11 = clear.
- `idx`, input, 4*IDXW: bit index per requester, in `idx[k*IDXW +: IDXW]`.
- `gnt`, output, 4: registered one-hot grant. Pulses high for one cycle.
- `err`, output, 1: registered. Pulses with `gnt` when the granted `idx` >= `WIDTH`.
- `q`, output, WIDTH: registered flip-flop bank state.
- `conflict_cnt`, output, 8: contention counter. See Configuration.

## Operation

- **Reset (async, `rst`=1).** `q`=0, `gnt`=0, `err`=0, `ptr`=0, `conflict_cnt`=0. Reset takes effect immediately, mid-command included. A command pending at reset is lost, and the requester must re-issue it.
- **Eligibility.** Requester k is eligible when `req[k]`=1 and `gnt[k]`=0. A requester that is being granted this cycle is masked, so it cannot win twice back to back.
- **Arbitration.** Eligible requesters are searched in the order `ptr`, `ptr+1`, … mod 4. The first one found wins.
- **On a win by requester w at the clock edge:**
  - `gnt` <= one-hot(w).
  - `ptr` <= (w+1) mod 4.
  - The opcode is applied to `q[idx_w]`:
    - toggle: `q[i]` <= ~`q[i]`.
    - set: `q[i]` <= 1.
    - clear: `q[i]` <= 0.
    - nop: `q` unchanged, but the grant is still issued.
- **Out-of-range index.** If `idx_w` >= `WIDTH`, `q` is unchanged, `gnt` is still issued, and `err` <= 1.
- **No eligible requester.** `gnt` <= 0, `err` <= 0, and `ptr` and `q` hold.
- **Single write path.** Only the winning command modifies `q`. All other bits hold.
- **Requester protocol.**
  - Hold `req`, `op` and `idx` stable until `gnt[k]` is seen.
  - Deassert `req[k]` in the grant cycle, or hold it to issue the same command again.
  - A requester that holds `req` continuously is served at most every other cycle. Under full load, service rotates 0→1→2→3.
- **Starvation bound.** Any requester that holds `req` is granted within 4 cycles.

## Timing

- **Latency.** `req` is sampled at edge n, and `gnt` and the updated `q` are visible together after edge n. There is one cycle from request to grant, with no combinational path from `req` to `gnt`.
- **Throughput.** One command per cycle across all requesters.
- **`q` readback.** The new value is readable in the same cycle that `gnt` is high.
- **Simultaneous requests on the same bit.** Only the winner applies its command. The loser is applied in a later cycle against the updated `q`. For example, two toggles on bit 2 return the bit to its original value after 2 grants.
- **Pointer wrap.** A grant to requester 3 sets `ptr` to 0.

## Configuration

- **`TFF_ARB_STATS_EN` defined:** `conflict_cnt` increments on every cycle in which two or more requesters are eligible. It saturates at 255 and is cleared only by `rst`.
- **`TFF_ARB_STATS_EN` undefined:** `conflict_cnt` is tied to 0 and no counter logic is built. Arbitration behaviour is identical in both builds.

## Test plan

- **Reset mid-command.** Assert `rst` asynchronously while `req`=0001 and `q`=8'h05. Required: `q`=0, `gnt`=0 and `ptr`=0 immediately. After release with `req` held, `gnt`=0001 one cycle later.
- **Single requester ops.** Requester 1 issues set idx 3, then toggle idx 3, then clear idx 0, starting from `q`=0. Required: `q`=8'h08, then 8'h00, then 8'h00, with `gnt`=0010 on each grant and the requester served every other cycle.
- **Round-robin fairness.** Hold `req`=1111 with toggle ops on idx 0..3. Required:
  - Grant order 0001, 0010, 0100, 1000, 0001.
  - `q` reaches 8'h0F after 4 grants.
  - With stats enabled, `conflict_cnt` increments every cycle.
- **Same-bit collision.** Requesters 0 and 2 both toggle idx 5, with `ptr`=0 and `q`=0. Required: `gnt`=0001 with `q`=8'h20, then `gnt`=0100 with `q`=8'h00.
- **Out-of-range index.** Requester 3 sets idx 7 with `WIDTH`=6, `IDXW`=3. Required: `gnt`=1000, `err`=1 for one cycle, `q` unchanged.
- **Saturation.** With `TFF_ARB_STATS_EN` defined, drive 300 contended cycles. Required: `conflict_cnt`=255 and it holds there. With the macro undefined, `conflict_cnt` stays 0.
